// File: rtl/regfile_bypass_sb_pkg.sv
// regfile_bypass_sb_pkg: shared default widths for the bypassing register file
package regfile_bypass_sb_pkg;
  localparam int S_W = 3;
  localparam int N_W = 16;
endpackage

// File: rtl/regfile_bypass_sb_if.sv
// regfile_bypass_sb_if: read/write/reserve port bundle of the register file
interface regfile_bypass_sb_if
  import regfile_bypass_sb_pkg::*;
#(
  parameter int s = S_W,
  parameter int n = N_W
);
  logic         gwe;
  logic [s-1:0] rs_sel;
  logic [s-1:0] rt_sel;
  logic [n-1:0] rs_data;
  logic [n-1:0] rt_data;
  logic         rs_busy;
  logic         rt_busy;
  logic [s-1:0] rd_sel;
  logic         rd_we;
  logic [n-1:0] rd_data;
  logic [s-1:0] rsv_sel;
  logic         rsv_en;
  logic         any_busy;
  modport master (
    output gwe, rs_sel, rt_sel, rd_sel, rd_we, rd_data, rsv_sel, rsv_en,
    input  rs_data, rt_data, rs_busy, rt_busy, any_busy
  );
  modport slave (
    input  gwe, rs_sel, rt_sel, rd_sel, rd_we, rd_data, rsv_sel, rsv_en,
    output rs_data, rt_data, rs_busy, rt_busy, any_busy
  );
endinterface

// File: rtl/regfile_bypass_sb_nbit_reg.sv
// regfile_bypass_sb_nbit_reg: n-bit register, async active-high clear, sync enable
module regfile_bypass_sb_nbit_reg #(
  parameter int n = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic [n-1:0] i_d,
  output logic [n-1:0] o_q
);
  logic [n-1:0] r_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_q <= '0;
    else if (i_en) r_q <= i_d;
  assign o_q = r_q;
endmodule

// File: rtl/regfile_bypass_sb.sv
// regfile_bypass_sb: 2**s x n register file with write-to-read bypass and busy scoreboard
module regfile_bypass_sb
  import regfile_bypass_sb_pkg::*;
#(
  parameter int s = S_W,
  parameter int n = N_W
) (
  input logic              clk,
  input logic              rst,
  regfile_bypass_sb_if.slave i_rf
);
  localparam int l = 1 << s;
  logic [l-1:0]   w_hit;
  logic [l-1:0]   w_we;
  logic [l-1:0]   w_rsv;
  logic [l-1:0]   w_busy;
  logic [l-1:0]   w_busy_d;
  logic [l*n-1:0] w_bus;
  logic           w_wr;
  logic           w_rs_byp;
  logic           w_rt_byp;
  assign w_wr = i_rf.gwe & i_rf.rd_we;
  genvar i;
  for (i = 0; i < l; i++) begin : g_reg
    assign w_hit[i]    = i_rf.rd_we && (i_rf.rd_sel == s'(i));
    assign w_we[i]     = i_rf.gwe & w_hit[i];
    assign w_rsv[i]    = i_rf.rsv_en && (i_rf.rsv_sel == s'(i));
    // reserve is OR'd last so it overrides a same-cycle write-back clear
    assign w_busy_d[i] = (w_busy[i] & ~w_hit[i]) | w_rsv[i];
    regfile_bypass_sb_nbit_reg #(.n(n)) u_data (
      .clk  (clk),
      .rst  (rst),
      .i_en (w_we[i]),
      .i_d  (i_rf.rd_data),
      .o_q  (w_bus[i*n +: n])
    );
    regfile_bypass_sb_nbit_reg #(.n(1)) u_busy (
      .clk  (clk),
      .rst  (rst),
      .i_en (i_rf.gwe),
      .i_d  (w_busy_d[i]),
      .o_q  (w_busy[i])
    );
  end
  assign w_rs_byp      = w_wr && (i_rf.rd_sel == i_rf.rs_sel);
  assign w_rt_byp      = w_wr && (i_rf.rd_sel == i_rf.rt_sel);
  assign i_rf.rs_data  = w_rs_byp ? i_rf.rd_data : w_bus[i_rf.rs_sel*n +: n];
  assign i_rf.rt_data  = w_rt_byp ? i_rf.rd_data : w_bus[i_rf.rt_sel*n +: n];
  assign i_rf.rs_busy  = w_busy[i_rf.rs_sel] & ~w_rs_byp;
  assign i_rf.rt_busy  = w_busy[i_rf.rt_sel] & ~w_rt_byp;
  assign i_rf.any_busy = |w_busy;
endmodule
